// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline skid register:
//     state_t     - occupancy state; the encoding equals the entry count, so
//                   the occupancy port is driven straight from the state.
//     DEF_DATA_W  - default payload width (instr, pc, pc8 packed).
//     DEF_CNT_W   - default stall-counter width.
//     NOP         - instruction word presented downstream while no payload
//                   is live.
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no live entry
        ONE   = 2'd1,   // main entry live
        FULL  = 2'd2    // main and skid entries live
    } state_t;

    localparam int DEF_DATA_W = 96;
    localparam int DEF_CNT_W  = 16;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/perf_sat_counter.sv
// ----------------------------------------------------------------------------
// perf_sat_counter
//   Saturating event counter. Counts cycles with inc=1 and sticks at the
//   all-ones value instead of wrapping.
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous, active-low reset (clears the count)
//     inc   - count this cycle
//     cnt   - current count, W bits
// ----------------------------------------------------------------------------
module perf_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg
//   Two-entry pipeline register (main M + skid S) with valid/ready handshakes
//   on both sides. in_ready is registered, so out_ready never reaches it
//   combinationally; the skid entry absorbs the one payload that can arrive
//   in the cycle back-pressure appears. Full throughput at out_ready=1,
//   one-cycle latency from accept to out_valid.
//   Ports:
//     clk       - clock, rising edge
//     reset     - asynchronous, active-low reset
//     in_valid  - upstream offers in_data
//     in_data   - upstream payload, DATA_W bits
//     in_ready  - block accepts a payload this cycle (registered)
//     out_valid - out_data holds a live payload
//     out_data  - payload to downstream (NOP/zero when idle if ZERO_BUBBLE)
//     out_ready - downstream consumes the payload
//     flush     - kill every held payload; a same-cycle accept is dropped
//     occupancy - live entries, 0..2
//     stall_cnt - saturating count of cycles with out_valid & !out_ready
// ----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP);

    state_t            state, nxt_state;
    logic [DATA_W-1:0] m_data, nxt_m_data;
    logic [DATA_W-1:0] s_data, nxt_s_data;
    logic              rdy_q, nxt_rdy;
    logic              m_valid, s_valid;
    logic              accept, take;

    // Valid bits follow directly from the state: M is live in ONE/FULL,
    // S only in FULL.
    assign m_valid = (state != EMPTY);
    assign s_valid = (state == FULL);

    assign in_ready  = rdy_q;
    assign out_valid = m_valid;
    assign out_data  = (ZERO_BUBBLE && !m_valid) ? BUBBLE : m_data;
    assign occupancy = state;

    assign accept = in_valid & rdy_q;
    assign take   = m_valid & out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            m_data <= '0;
            s_data <= '0;
            rdy_q  <= 1'b1;
        end else begin
            state  <= nxt_state;
            m_data <= nxt_m_data;
            s_data <= nxt_s_data;
            rdy_q  <= nxt_rdy;
        end
    end

    // ------------------------------------------------------------------
    // Next state. In FULL rdy_q is 0, so accept is already masked and
    // in_valid cannot disturb the held pair.
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state  = state;
        nxt_m_data = m_data;
        nxt_s_data = s_data;

        unique case (state)
            EMPTY: begin
                if (accept) begin
                    nxt_m_data = in_data;
                    nxt_state  = ONE;
                end
            end
            ONE: begin
                if (accept && take) begin
                    nxt_m_data = in_data;
                end else if (accept) begin
                    nxt_s_data = in_data;
                    nxt_state  = FULL;
                end else if (take) begin
                    nxt_state  = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    nxt_m_data = s_data;
                    nxt_state  = ONE;
                end
            end
            default: begin
                nxt_state = EMPTY;
            end
        endcase

        // Flush wins over everything above; a take in the same cycle has
        // already been seen downstream, so it still counts as delivered.
        if (flush) begin
            nxt_state  = EMPTY;
            nxt_m_data = '0;
            nxt_s_data = '0;
        end

        // Ready for the next cycle is a function of the next state only,
        // which keeps out_ready off the combinational in_ready path.
        nxt_rdy = (nxt_state != FULL);
    end

    // ------------------------------------------------------------------
    // Back-pressure counter: independent of flush, cleared only by reset.
    // ------------------------------------------------------------------
    perf_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (m_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

    // s_valid only documents the skid entry; keep it referenced.
    logic unused_ok;
    assign unused_ok = s_valid;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Directed stimulus for pipe_skid_reg (CNT_W=4) with a scoreboard queue:
//   accepted payloads are pushed, every delivered payload is popped and
//   compared. Directed checks cover latency, occupancy, in_ready, flush,
//   stall counter saturation and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int DATA_W = 96;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    logic [DATA_W-1:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .DATA_W      (DATA_W),
        .CNT_W       (CNT_W),
        .ZERO_BUBBLE (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge, so values seen at the falling
    // edge are exactly what the next rising edge will sample.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: take pops and compares, flush drops everything
    // held, accept pushes the offered payload.
    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_unexpected: got %0h expected nothing", out_data);
                end else begin
                    check("sb_data", out_data, sb_q.pop_front());
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(in_data);
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_occupancy", occupancy, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        reset = 1'b1;
        step();

        // ---- single payload, one-cycle latency ----
        in_valid = 1'b1; in_data = 96'hA; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data",  out_data,  96'hA);
        check("lat_occupancy", occupancy, 1);
        step();
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_out_data",  out_data,  0);

        // ---- stream 1..8 at full rate ----
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(i);
            step();
            if (i == 8) in_valid = 1'b0;
            @(negedge clk);
            check("strm_out_data", out_data, DATA_W'(i));
            check("strm_in_ready", in_ready, 1);
        end
        step();
        @(negedge clk);
        check("strm_drained", occupancy, 0);

        // ---- skid fill, drain, payload offered while FULL ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'h5;
        step();
        in_data = 96'h6;
        step();
        in_data = 96'h7;
        @(negedge clk);
        check("full_occupancy", occupancy, 2);
        check("full_in_ready",  in_ready,  0);
        check("full_out_data",  out_data,  96'h5);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("full_hold_occ", occupancy, 2);
        check("full_hold_dat", out_data,  96'h5);
        step();
        @(negedge clk);
        check("drain_out_6",   out_data,  96'h6);
        check("drain_in_rdy",  in_ready,  1);
        check("drain_occ",     occupancy, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("drain_out_7",   out_data,  96'h7);
        step();
        @(negedge clk);
        check("drain_empty",   occupancy, 0);
        check("stall_after_skid", stall_cnt, 2);

        // ---- flush while FULL with a payload offered ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'h10;
        step();
        in_data = 96'h11;
        step();
        flush = 1'b1; in_data = 96'h9;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl_occupancy", occupancy, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_out_data",  out_data,  0);
        check("fl_in_ready",  in_ready,  1);
        check("fl_stall_cnt", stall_cnt, 4);
        out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check("fl_no_9", out_valid, 0);

        // ---- stall counter saturation ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'h55;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        @(negedge clk);
        check("sat_15", stall_cnt, 15);
        repeat (3) step();
        @(negedge clk);
        check("sat_held", stall_cnt, 15);
        out_ready = 1'b1;
        step();
        @(negedge clk);
        check("sat_after_drain", stall_cnt, 15);

        // ---- asynchronous reset in the middle of FULL ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 96'h21;
        step();
        in_data = 96'h22;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("arst_in_ready",  in_ready,  1);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data",  out_data,  0);
        check("arst_occupancy", occupancy, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        in_valid = 1'b0;
        step();
        reset = 1'b1;

        // ---- first accept after reset release ----
        in_valid = 1'b1; in_data = 96'h33; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_data", out_data,  96'h33);
        check("post_rst_occ",  occupancy, 1);
        repeat (3) step();
        @(negedge clk);
        check("sb_leftover", DATA_W'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, giving the payload width (instr, pc, pc8 packed).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-003 The block SHALL have parameter ZERO_BUBBLE, default 1; when 1, out_data reads all-zero (NOP) whenever out_valid=0.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream stage offers in_data.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: the upstream payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a payload this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a live payload.
REQ-010 The block SHALL have port out_data, output, DATA_W bits: the payload presented downstream.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes the payload (replaces en = ~stall).
REQ-012 The block SHALL have port flush, input, 1 bit: kill all held payloads (replaces clr).
REQ-013 The block SHALL have port occupancy, output, 2 bits: the number of live entries, 0..2.
REQ-014 The block SHALL have port stall_cnt, output, CNT_W bits: the saturating count of back-pressured cycles.

Function
REQ-015 The block SHALL hold two entries, main M and skid S, each a valid bit plus DATA_W data, with states EMPTY (none), ONE (M), FULL (M+S).
REQ-016 The block SHALL define accept = in_valid & in_ready and take = out_valid & out_ready.
REQ-017 The block SHALL drive out_valid = M.valid and out_data = M.data, except as REQ-003 requires.
REQ-018 The block SHALL drive in_ready from a register, 1 in EMPTY/ONE and 0 in FULL, with no combinational path from out_ready.
REQ-019 In EMPTY: accept SHALL load M and go to ONE; otherwise the block stays in EMPTY.
REQ-020 In ONE: accept&take SHALL load M from in_data (stay ONE); accept&!take SHALL load S (go FULL); !accept&take SHALL go EMPTY; neither SHALL hold.
REQ-021 In FULL: take SHALL move S to M (go ONE); !take SHALL hold; in_valid SHALL be ignored.
REQ-022 Latency SHALL be one cycle from accept in EMPTY to out_valid=1; sustained throughput SHALL be one payload per cycle with out_ready=1.
REQ-023 Payloads SHALL leave in acceptance order, bit-exact, each exactly once.
REQ-024 On flush=1, the next state SHALL be EMPTY with both data fields zeroed; a same-cycle accept SHALL be dropped.
REQ-025 A take coinciding with flush SHALL still count as delivered; in_ready SHALL be 1 the cycle after flush.
REQ-026 stall_cnt SHALL increment by 1 every cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-027 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL, updated with the state.

Reset
REQ-028 When reset=0 (asynchronous), the block SHALL drive M.valid=S.valid=0, data=0, in_ready=1, out_valid=0, out_data=0, occupancy=0, stall_cnt=0.
REQ-029 Reset SHALL override flush and any in-flight transfer; the first accept after release SHALL behave as in EMPTY.

Structure
REQ-030 Package pipe_pkg SHALL hold the state encoding (EMPTY/ONE/FULL), the default DATA_W/CNT_W, and the NOP constant 32'h0000_0000.
REQ-031 The saturating counter SHALL be sub-module perf_sat_counter (parameter W; ports clk, reset, inc, cnt); the rest SHALL be flat.

Verification
REQ-032 The bench SHALL cover: after reset, in_data=96'hA, in_valid=1, out_ready=1 -> out_valid=1, out_data=96'hA next cycle; occupancy=1.
REQ-033 The bench SHALL cover: stream 1..8 with out_ready=1 -> outputs 1..8 on consecutive cycles, in_ready stays 1.
REQ-034 The bench SHALL cover: accept 5, 6 with out_ready=0 -> occupancy=2, in_ready=0; then out_ready=1 -> 5 then 6 out, and 7 offered during FULL is not lost (accepted once in_ready=1).
REQ-035 The bench SHALL cover: FULL with flush=1 and in_valid=1 (data 9) -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1; 9 never appears.
REQ-036 The bench SHALL cover: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15, then held.
REQ-037 The bench SHALL cover: reset asserted mid-FULL between clock edges -> all outputs at reset values immediately, without waiting for a clock edge.
